// File: rtl/spi_process_image_buffer.sv
// Double-buffered process image between the byte-level SPI slave engine and the application.
// RX bytes fill a shadow image that is committed atomically on a clean frame; TX streams a frame-start snapshot.
module spi_process_image_buffer #(
    parameter int         IMAGE_BYTES = 64,
    parameter int         BIT_REVERSE = 1,
    parameter logic [7:0] FILL_BYTE   = 8'h00,
    parameter int         ERR_W       = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_frame_start,
    input  logic                       i_frame_end,
    input  logic                       i_rx_valid,
    input  logic [7:0]                 i_rx_byte,
    input  logic                       i_tx_req,
    output logic [7:0]                 o_tx_byte,
    output logic                       o_tx_valid,
    input  logic [IMAGE_BYTES*8-1:0]   i_image_in,
    output logic [IMAGE_BYTES*8-1:0]   o_image_out,
    output logic                       o_image_update,
    output logic                       o_frame_err,
    output logic [ERR_W-1:0]           o_err_count
);

    localparam int IDX_W = $clog2(IMAGE_BYTES + 2);
    localparam logic [IDX_W-1:0] LP_FULL = IDX_W'(IMAGE_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_COMMIT
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic [IMAGE_BYTES*8-1:0] r_shadow;
    logic [IMAGE_BYTES*8-1:0] r_snap;
    logic [IMAGE_BYTES*8-1:0] r_image_out;
    logic [IDX_W-1:0]         r_rx_idx;
    logic [IDX_W-1:0]         r_tx_idx;
    logic                     r_overrun;
    logic [7:0]               r_tx_byte;
    logic                     r_tx_valid;
    logic                     r_update;
    logic                     r_frame_err;
    logic [ERR_W-1:0]         r_err_count;

    logic                     w_active;
    logic                     w_rx_write;
    logic                     w_rx_over;
    logic [IDX_W-1:0]         w_rx_idx_next;
    logic                     w_overrun_next;
    logic [IMAGE_BYTES*8-1:0] w_shadow_next;
    logic                     w_end_frame;
    logic                     w_abort;
    logic                     w_accept;
    logic                     w_reject;
    logic                     w_tx_adv;
    logic [IDX_W-1:0]         w_tx_idx_inc;
    logic [7:0]               w_tx_fetch;

    function automatic logic [7:0] f_rev(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (BIT_REVERSE != 0) begin
            for (int i = 0; i < 8; i++) begin
                r[i] = b[7-i];
            end
        end
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A FRAME_START always wins: it aborts a running frame or overlaps the commit cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_frame_start) w_next_state = S_ACTIVE;
            S_ACTIVE: begin
                if (i_frame_start) begin
                    w_next_state = S_ACTIVE;
                end else if (i_frame_end) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: w_next_state = i_frame_start ? S_ACTIVE : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // The byte arriving with FRAME_END is folded in before the completeness check.
    always_comb begin
        w_active       = (r_state == S_ACTIVE);
        w_rx_write     = w_active && !i_frame_start && i_rx_valid && (r_rx_idx < LP_FULL);
        w_rx_over      = w_active && !i_frame_start && i_rx_valid && (r_rx_idx == LP_FULL);
        w_rx_idx_next  = w_rx_write ? r_rx_idx + IDX_W'(1) : r_rx_idx;
        w_overrun_next = r_overrun || w_rx_over;
        w_end_frame    = w_active && i_frame_end && !i_frame_start;
        w_abort        = w_active && i_frame_start;
        w_accept       = w_end_frame && (w_rx_idx_next == LP_FULL) && !w_overrun_next;
        w_reject       = w_abort || (w_end_frame && !w_accept);
        w_tx_adv       = w_active && i_tx_req && !i_frame_start && !i_frame_end;
        w_tx_idx_inc   = r_tx_idx + IDX_W'(1);
        w_shadow_next  = r_shadow;
        w_tx_fetch     = FILL_BYTE;
        for (int k = 0; k < IMAGE_BYTES; k++) begin
            if (w_rx_write && (r_rx_idx == IDX_W'(k))) begin
                w_shadow_next[8*k +: 8] = f_rev(i_rx_byte);
            end
            if (w_tx_idx_inc == IDX_W'(k)) begin
                w_tx_fetch = f_rev(r_snap[8*k +: 8]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow    <= '0;
            r_snap      <= '0;
            r_image_out <= '0;
            r_rx_idx    <= '0;
            r_tx_idx    <= '0;
            r_overrun   <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_update    <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_update    <= w_accept;
            r_frame_err <= w_reject;
            r_shadow    <= w_shadow_next;
            if (w_accept) begin
                r_image_out <= w_shadow_next;
            end
            if (w_reject && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
            if (i_frame_start) begin
                r_snap     <= i_image_in;
                r_rx_idx   <= '0;
                r_tx_idx   <= '0;
                r_overrun  <= 1'b0;
                r_tx_byte  <= f_rev(i_image_in[7:0]);
                r_tx_valid <= 1'b1;
            end else begin
                r_rx_idx  <= w_rx_idx_next;
                r_overrun <= w_overrun_next;
                if (w_tx_adv) begin
                    r_tx_byte <= w_tx_fetch;
                    if (r_tx_idx != LP_FULL) begin
                        r_tx_idx <= w_tx_idx_inc;
                    end
                end
                if (w_end_frame) begin
                    r_tx_valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_tx_byte      = r_tx_byte;
        o_tx_valid     = r_tx_valid;
        o_image_out    = r_image_out;
        o_image_update = r_update;
        o_frame_err    = r_frame_err;
        o_err_count    = r_err_count;
    end

endmodule
